// File: rtl/sig_accum_pkg.sv
// Shared types, default widths and the signed saturation helper for sig_accum_bins.
package sig_accum_pkg;

  localparam int unsigned ADC_W_DEF = 12;
  localparam int unsigned ACC_W_DEF = 24;
  localparam int unsigned OUT_W_DEF = 16;
  localparam int unsigned BINS_DEF  = 16;
  localparam int unsigned CNT_W_DEF = 10;
  localparam int unsigned SAT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    ACQ   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [SAT_MAX_W-1:0] sat_signed(
    input logic signed [SAT_MAX_W-1:0] v,
    input int unsigned                 w
  );
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    hi = $signed((SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1));
    lo = ~hi;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/sig_accum_shift_sat.sv
// Readout datapath: arithmetic right shift (clamped to ACC_W-1) then saturation to OUT_W.
import sig_accum_pkg::*;

module sig_accum_shift_sat #(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF
) (
  input  logic [ACC_W-1:0] i_val,
  input  logic [4:0]       i_shift,
  output logic [OUT_W-1:0] o_val_c
);

  localparam int unsigned SH_MAX = ACC_W - 1;

  logic [4:0]                  w_sh;
  logic signed [ACC_W-1:0]     w_shifted;
  logic signed [SAT_MAX_W-1:0] w_wide;

  assign w_sh      = (32'(i_shift) > SH_MAX) ? 5'(SH_MAX) : i_shift;
  assign w_shifted = $signed(i_val) >>> w_sh;
  assign w_wide    = {{(SAT_MAX_W-ACC_W){w_shifted[ACC_W-1]}}, w_shifted};
  assign o_val_c   = OUT_W'(sat_signed(w_wide, OUT_W));

endmodule

// File: rtl/sig_accum_bins.sv
// Coherent phase-bin accumulator: clears bins, sums ADC samples per bin over acqnum periods,
// then serves shifted/saturated readout. SIG_ACCUM_SAT_EN makes the bin add saturate instead of wrap.
import sig_accum_pkg::*;

module sig_accum_bins #(
  parameter int unsigned ADC_W = ADC_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned OUT_W = OUT_W_DEF,
  parameter int unsigned BINS  = BINS_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  localparam int unsigned PW   = $clog2(BINS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             start,
  input  logic [PW-1:0]    periodnum,
  input  logic [CNT_W-1:0] acqnum,
  input  logic [4:0]       addchoice,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             rd_en,
  input  logic [PW-1:0]    rd_addr,
  output logic             rd_valid,
  output logic [OUT_W-1:0] rd_data,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  state_t r_state;
  state_t w_state_nxt;

  logic [PW-1:0]    r_periodnum;
  logic [CNT_W-1:0] r_acqnum;
  logic [4:0]       r_addchoice;
  logic [PW-1:0]    r_bin_ptr;
  logic [CNT_W-1:0] r_period_cnt;
  logic [ACC_W-1:0] r_bin [BINS];

  logic             r_rd_valid;
  logic [OUT_W-1:0] r_rd_data;
  logic             r_busy;
  logic             r_done;
  logic             r_overflow;

  logic             w_idle_or_done;
  logic             w_ptr_last;
  logic             w_period_last;
  logic             w_sample_en;
  logic [CNT_W-1:0] w_acq_target;
  logic [ACC_W-1:0] w_cur;
  logic [ACC_W:0]   w_sum_ext;
  logic             w_add_ovf;
  logic [ACC_W-1:0] w_sum;
  logic [OUT_W-1:0] w_rd_shifted;

  assign w_idle_or_done = (r_state == IDLE) || (r_state == DONE);
  assign w_ptr_last     = (r_bin_ptr == r_periodnum);
  assign w_acq_target   = (r_acqnum == '0) ? CNT_W'(1) : r_acqnum;
  assign w_period_last  = ((r_period_cnt + CNT_W'(1)) == w_acq_target);
  assign w_sample_en    = (r_state == ACQ) && adc_valid;

  // One guard bit catches signed overflow of the bin add.
  assign w_cur     = r_bin[r_bin_ptr];
  assign w_sum_ext = {w_cur[ACC_W-1], w_cur}
                   + {{(ACC_W+1-ADC_W){adc_data[ADC_W-1]}}, adc_data};
  assign w_add_ovf = w_sum_ext[ACC_W] ^ w_sum_ext[ACC_W-1];

`ifdef SIG_ACCUM_SAT_EN
  assign w_sum = !w_add_ovf       ? w_sum_ext[ACC_W-1:0] :
                 w_sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                    {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign w_sum = w_sum_ext[ACC_W-1:0];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CLEAR;
      CLEAR:   if (w_ptr_last) w_state_nxt = ACQ;
      ACQ:     if (adc_valid && w_ptr_last && w_period_last) w_state_nxt = DONE;
      DONE:    if (start) w_state_nxt = CLEAR;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Configuration, bin pointer, period counter, status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_periodnum  <= '0;
      r_acqnum     <= '0;
      r_addchoice  <= '0;
      r_bin_ptr    <= '0;
      r_period_cnt <= '0;
      r_overflow   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      if (load && w_idle_or_done) begin
        r_periodnum <= periodnum;
        r_acqnum    <= acqnum;
        r_addchoice <= addchoice;
      end
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_bin_ptr    <= '0;
            r_period_cnt <= '0;
            r_overflow   <= 1'b0;
          end
        end
        CLEAR: r_bin_ptr <= w_ptr_last ? '0 : r_bin_ptr + PW'(1);
        ACQ: begin
          if (adc_valid) begin
            r_bin_ptr <= w_ptr_last ? '0 : r_bin_ptr + PW'(1);
            if (w_ptr_last) r_period_cnt <= r_period_cnt + CNT_W'(1);
            if (w_add_ovf)  r_overflow   <= 1'b1;
          end
        end
        default: ;
      endcase
      r_busy <= (w_state_nxt == CLEAR) || (w_state_nxt == ACQ);
      r_done <= (w_state_nxt == DONE);
    end
  end

  // Bin storage: synchronous write, asynchronous read; untouched by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == CLEAR)  r_bin[r_bin_ptr] <= '0;
      else if (w_sample_en)  r_bin[r_bin_ptr] <= w_sum;
    end
  end

  sig_accum_shift_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_shift_sat (
    .i_val   (r_bin[rd_addr]),
    .i_shift (r_addchoice),
    .o_val_c (w_rd_shifted)
  );

  // Registered read port; busy phases and out-of-range bins read as zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= rd_en;
      r_rd_data  <= (rd_en && w_idle_or_done && (rd_addr <= r_periodnum)) ? w_rd_shifted : '0;
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_sig_accum_bins.sv
// Self-checking bench for sig_accum_bins: vector table of acquisition runs plus control corner cases.
module tb_sig_accum_bins;

  logic        clk = 1'b0;
  logic        reset, load, start, adc_valid, rd_en;
  logic [3:0]  periodnum, rd_addr;
  logic [9:0]  acqnum;
  logic [4:0]  addchoice;
  logic [11:0] adc_data;

  logic        rd_valid, busy, done, overflow;
  logic [15:0] rd_data;
  logic        rd_valid14, busy14, done14, overflow14;
  logic [15:0] rd_data14;

  always #5 clk = ~clk;

  sig_accum_bins #(
    .ADC_W(12), .ACC_W(24), .OUT_W(16), .BINS(16), .CNT_W(10)
  ) u_dut (
    .clk(clk), .reset(reset), .load(load), .start(start),
    .periodnum(periodnum), .acqnum(acqnum), .addchoice(addchoice),
    .adc_valid(adc_valid), .adc_data(adc_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .done(done), .overflow(overflow)
  );

  sig_accum_bins #(
    .ADC_W(12), .ACC_W(14), .OUT_W(16), .BINS(16), .CNT_W(10)
  ) u_dut14 (
    .clk(clk), .reset(reset), .load(load), .start(start),
    .periodnum(periodnum), .acqnum(acqnum), .addchoice(addchoice),
    .adc_valid(adc_valid), .adc_data(adc_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_valid(rd_valid14), .rd_data(rd_data14),
    .busy(busy14), .done(done14), .overflow(overflow14)
  );

  typedef struct {
    int pnum; int anum; int shift; int s0; int step;
    int e0; int e1; int e2; int e3; int ovf;
  } vec_t;

  localparam int NVEC = 6;
  vec_t vecs [NVEC];

  int checks   = 0;
  int failures = 0;
  int exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one read on the main DUT; expected value goes through the scoreboard queue.
  task automatic rd_issue(input int addr, input int exp, input string name);
    rd_en   = 1'b1;
    rd_addr = 4'(addr);
    exp_q.push_back(exp);
    tick();
    rd_en = 1'b0;
    check({name, "_valid"}, int'(rd_valid), 1);
    if (rd_valid) begin
      if (exp_q.size() == 0) check({name, "_sb_empty"}, 1, 0);
      else                   check(name, int'($signed(rd_data)), exp_q.pop_front());
    end
  endtask

  // Load+start a run, wait out CLEAR, feed (pnum+1)*max(anum,1) samples s0 + bin*step.
  task automatic run_acq(input int pnum, input int anum, input int shift,
                         input int s0, input int step, input string tag);
    int n;
    periodnum = 4'(pnum);
    acqnum    = 10'(anum);
    addchoice = 5'(shift);
    load      = 1'b1;
    start     = 1'b1;
    tick();
    load  = 1'b0;
    start = 1'b0;
    check({tag, "_busy_start"}, int'(busy), 1);
    check({tag, "_ovf_clr"}, int'(overflow14), 0);
    repeat (pnum + 1) tick();
    n = (pnum + 1) * ((anum == 0) ? 1 : anum);
    for (int k = 0; k < n; k++) begin
      if (k == n - 1) check({tag, "_done_early"}, int'(done), 0);
      adc_valid = 1'b1;
      adc_data  = 12'(s0 + (k % (pnum + 1)) * step);
      tick();
    end
    adc_valid = 1'b0;
    check({tag, "_done"}, int'(done), 1);
    check({tag, "_busy_end"}, int'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{3, 4,    0,  1,     1,   4,     8,  12, 16, 0};
    vecs[1] = '{0, 8,    3, -2048,  0,  -2048,  0,  0,  0,  0};
    vecs[2] = '{0, 8,    0, -2048,  0,  -16384, 0,  0,  0,  0};
    vecs[3] = '{0, 1023, 0,  2047,  0,   32767, 0,  0,  0,  0};
    vecs[4] = '{1, 0,    1,  5,     3,   2,     4,  0,  0,  0};
    vecs[5] = '{2, 3,    31, -7,    100, -1,    0,  0,  0,  0};

    reset = 1'b1; load = 1'b0; start = 1'b0; adc_valid = 1'b0; rd_en = 1'b0;
    periodnum = '0; acqnum = '0; addchoice = '0; adc_data = '0; rd_addr = '0;
    tick();
    tick();
    check("rst_busy",     int'(busy),     0);
    check("rst_done",     int'(done),     0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_data",  int'(rd_data),  0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      run_acq(vecs[i].pnum, vecs[i].anum, vecs[i].shift, vecs[i].s0, vecs[i].step,
              $sformatf("vec%0d", i));
      check($sformatf("vec%0d_ovf", i), int'(overflow), vecs[i].ovf);
      rd_issue(0, vecs[i].e0, $sformatf("vec%0d_bin0", i));
      rd_issue(1, vecs[i].e1, $sformatf("vec%0d_bin1", i));
      rd_issue(2, vecs[i].e2, $sformatf("vec%0d_bin2", i));
      rd_issue(3, vecs[i].e3, $sformatf("vec%0d_bin3", i));
    end

    // load/start/rd_en during ACQ: config change and restart ignored, read returns 0
    periodnum = 4'd1; acqnum = 10'd2; addchoice = 5'd0;
    load = 1'b1; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 4; k++) begin
      adc_valid = 1'b1;
      adc_data  = 12'(10 + (k % 2));
      if (k == 1) begin
        load = 1'b1; start = 1'b1;
        periodnum = 4'd0; acqnum = 10'd1; addchoice = 5'd5;
        rd_en = 1'b1; rd_addr = 4'd0;
        exp_q.push_back(0);
      end
      tick();
      if (k == 1) begin
        load = 1'b0; start = 1'b0; rd_en = 1'b0;
        check("ctl_rd_valid_acq", int'(rd_valid), 1);
        if (exp_q.size() > 0) check("ctl_rd_data_acq", int'($signed(rd_data)), exp_q.pop_front());
        check("ctl_busy_after_start", int'(busy), 1);
        check("ctl_done_after_load",  int'(done), 0);
      end
    end
    adc_valid = 1'b0;
    check("ctl_done", int'(done), 1);
    rd_issue(0, 20, "ctl_bin0");
    rd_issue(1, 22, "ctl_bin1");
    tick();
    check("ctl_rd_valid_pulse", int'(rd_valid), 0);

    // Accumulator overflow on the 14-bit instance
    run_acq(0, 5, 0, 2047, 0, "ovf");
    check("ovf14_set",   int'(overflow14), 1);
    check("ovf24_clear", int'(overflow),   0);
    rd_issue(0, 10235, "ovf_bin24");
    check("ovf14_rd_valid", int'(rd_valid14), 1);
`ifdef SIG_ACCUM_SAT_EN
    check("ovf14_bin", int'($signed(rd_data14)), 8191);
`else
    check("ovf14_bin", int'($signed(rd_data14)), -6149);
`endif

    // Reset mid-ACQ, then a fresh short run must see no stale bin data
    periodnum = 4'd3; acqnum = 10'd4; addchoice = 5'd0;
    load = 1'b1; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    repeat (4) tick();
    for (int k = 0; k < 3; k++) begin
      adc_valid = 1'b1;
      adc_data  = 12'd100;
      tick();
    end
    check("rst_mid_busy_before", int'(busy), 1);
    reset = 1'b1;
    tick();
    adc_valid = 1'b0;
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(done), 0);
    reset = 1'b0;
    tick();
    run_acq(1, 1, 0, 5, 1, "post_rst");
    rd_issue(0, 5, "post_rst_bin0");
    rd_issue(1, 6, "post_rst_bin1");
    rd_issue(2, 0, "post_rst_bin2_oob");

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
